// File: rtl/sram_pkg.sv
// Shared types and constants for the 32-bit word to 16-bit SRAM sequencer.
package sram_pkg;

  // Byte address that maps onto SRAM word 0.
  localparam int unsigned BASE_ADDR = 1024;
  // SRAM half-word address width.
  localparam int unsigned SRAM_AW   = 18;
  // SRAM data bus width.
  localparam int unsigned DQ_W      = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/sram_word_controller.sv
// Splits a 32-bit word access into two half-word phases on the external SRAM.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no access in flight; a request is latched and starts LO
//   LO    | even half-word ({idx,0}) on the pins for WAIT_CYCLES cycles
//   HI    | odd half-word ({idx,1}) on the pins for WAIT_CYCLES cycles
//   DONE  | one-cycle completion handshake (ready=1), then IDLE
module sram_word_controller
  import sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  inout  wire  [DQ_W-1:0]    SRAM_DQ,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic               SRAM_CE_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_OE_N
);

  localparam int unsigned CNT_W = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   wr_q;
  logic [SRAM_AW-2:0]     idx_q;
  logic [DQ_W-1:0]        wdata_hi_q;
  logic [2*DQ_W-1:0]      read_data_q;
  logic [SRAM_AW-1:0]     sram_addr_q;
  logic                   we_n_q;
  logic                   oe_n_q;
  logic                   dq_oe_q;
  logic [DQ_W-1:0]        dq_out_q;

  logic [31:0]            byte_off;
  logic [SRAM_AW-2:0]     idx_in;
  logic                   phase_end;
  logic                   unused_off;

  // Word index relative to the mapped base; upper bits wrap silently.
  assign byte_off   = address - BASE_ADDR;
  assign idx_in     = byte_off[SRAM_AW:2];
  assign unused_off = ^{byte_off[31:SRAM_AW+1], byte_off[1:0]};

  assign phase_end  = (cnt_q == CNT_LAST);

  // Sequencer: latches the request in IDLE and drives registered pin controls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      idx_q       <= '0;
      wdata_hi_q  <= '0;
      read_data_q <= '0;
      sram_addr_q <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_en || wr_en) begin
            // A simultaneous read and write request is treated as a write.
            wr_q        <= wr_en;
            idx_q       <= idx_in;
            wdata_hi_q  <= write_data[2*DQ_W-1:DQ_W];
            cnt_q       <= '0;
            sram_addr_q <= {idx_in, 1'b0};
            we_n_q      <= ~wr_en;
            oe_n_q      <= wr_en;
            dq_oe_q     <= wr_en;
            dq_out_q    <= write_data[DQ_W-1:0];
            state_q     <= LO;
          end
        end
        LO: begin
          if (phase_end) begin
            if (!wr_q) begin
              read_data_q[DQ_W-1:0] <= SRAM_DQ;
            end
            // WE_N stays low across the boundary; only address and data move.
            cnt_q       <= '0;
            sram_addr_q <= {idx_q, 1'b1};
            dq_out_q    <= wdata_hi_q;
            state_q     <= HI;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HI: begin
          if (phase_end) begin
            if (!wr_q) begin
              read_data_q[2*DQ_W-1:DQ_W] <= SRAM_DQ;
            end
            cnt_q   <= '0;
            we_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Handshake: falls as soon as a request appears in IDLE, pulses in DONE.
  assign ready = (state_q == DONE) || ((state_q == IDLE) && !rd_en && !wr_en);

  assign SRAM_DQ   = dq_oe_q ? dq_out_q : {DQ_W{1'bz}};
  assign SRAM_ADDR = sram_addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign read_data = read_data_q;

endmodule

// File: tb/tb_sram_word_controller.sv
// Directed and randomized checks of sram_word_controller against a word-level model.
module tb_sram_word_controller;

  localparam int W = 2;
  localparam int NWORDS_MOD = 131072;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  wire  [31:0] read_data;
  wire         ready;
  // Pulled high so a released bus reads as all-ones.
  tri1  [15:0] sram_dq;
  wire  [17:0] sram_addr;
  wire         sram_ub_n, sram_lb_n, sram_ce_n, sram_we_n, sram_oe_n;

  logic        sram_drv;
  logic [15:0] sram [0:262143];
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] exp_rd;

  int checks;
  int errors;

  sram_word_controller #(.WAIT_CYCLES(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_DQ    (sram_dq),
    .SRAM_ADDR  (sram_addr),
    .SRAM_UB_N  (sram_ub_n),
    .SRAM_LB_N  (sram_lb_n),
    .SRAM_CE_N  (sram_ce_n),
    .SRAM_WE_N  (sram_we_n),
    .SRAM_OE_N  (sram_oe_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // External SRAM: asynchronous read onto DQ, write sampled on the clock.
  assign sram_dq = (sram_drv && !sram_ce_n && !sram_oe_n && sram_we_n) ? sram[sram_addr] : 16'hzzzz;

  always @(posedge clk) begin
    if (!sram_we_n && !sram_ce_n) sram[sram_addr] <= sram_dq;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] init_pat(input int unsigned k);
    logic [31:0] t;
    t = (k * 32'd40503) ^ 32'h0000_5A5A;
    return t[15:0];
  endfunction

  function automatic int unsigned word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return (off / 32'd4) % NWORDS_MOD;
  endfunction

  function automatic logic [31:0] ref_word(input int unsigned i);
    if (ref_mem.exists(i)) return ref_mem[i];
    return {init_pat(2 * i + 1), init_pat(2 * i)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access, starting just after a rising edge with the DUT in IDLE.
  // drop_at > 0 removes the request (and scrambles address/data) in that cycle.
  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                        input int drop_at, input bit drv, input string tag);
    int unsigned idx;
    int done_c, we_low, oe_low, addr_bad, dq_bad;
    logic [31:0] exp_word;
    logic [31:0] rd_done;
    bit hi;
    idx      = word_of(addr);
    exp_word = wr ? data : (drv ? ref_word(idx) : 32'hFFFF_FFFF);
    done_c   = -1;
    we_low   = 0;
    oe_low   = 0;
    addr_bad = 0;
    dq_bad   = 0;
    rd_done  = 'x;
    sram_drv   = drv;
    address    = addr;
    write_data = data;
    wr_en      = wr;
    rd_en      = !wr;
    for (int c = 0; c < 4 * W + 8; c++) begin
      @(negedge clk);
      if (c == 0) check({tag, "_ready_fall"}, 32'(ready), 32'd0);
      if (!sram_we_n) we_low++;
      if (!sram_oe_n) oe_low++;
      if (c >= 1 && c <= 2 * W) begin
        hi = (c > W);
        if ({14'd0, sram_addr} !== 32'(2 * idx + (hi ? 1 : 0))) addr_bad++;
        if (wr && sram_dq !== (hi ? data[31:16] : data[15:0])) dq_bad++;
      end
      if (!wr && !drv && sram_dq !== 16'hFFFF) dq_bad++;
      if (ready && c > 0) begin
        done_c  = c;
        rd_done = read_data;
        break;
      end
      @(posedge clk);
      #1;
      if (c + 1 == drop_at) begin
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        address    = $urandom;
        write_data = $urandom;
      end
    end
    if (wr) ref_mem[idx] = data;
    else exp_rd = exp_word;
    check({tag, "_latency"}, 32'(done_c), 32'(2 * W + 1));
    check({tag, "_rdata"}, rd_done, exp_rd);
    check({tag, "_we_low"}, 32'(we_low), wr ? 32'(2 * W) : 32'd0);
    check({tag, "_oe_low"}, 32'(oe_low), wr ? 32'd0 : 32'(2 * W));
    check({tag, "_addr"}, 32'(addr_bad), 32'd0);
    check({tag, "_dq"}, 32'(dq_bad), 32'd0);
    @(posedge clk);
    #1;
    rd_en    = 1'b0;
    wr_en    = 1'b0;
    sram_drv = 1'b1;
  endtask

  initial begin
    logic [31:0] b2b_exp;
    checks     = 0;
    errors     = 0;
    exp_rd     = 32'd0;
    rst        = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    address    = 32'd0;
    write_data = 32'd0;
    sram_drv   = 1'b1;
    for (int i = 0; i < 262144; i++) sram[i] = init_pat(i);

    // Reset and idle outputs.
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_we_n", 32'(sram_we_n), 32'd1);
    check("rst_oe_n", 32'(sram_oe_n), 32'd1);
    check("rst_dq_released", 32'(sram_dq), 32'h0000_FFFF);
    check("rst_read_data", read_data, 32'd0);
    check("rst_sram_addr", 32'(sram_addr), 32'd0);
    check("tied_ctrl", {29'd0, sram_ub_n, sram_lb_n, sram_ce_n}, 32'd0);
    @(posedge clk);
    #1;

    // Basic write then read at the base address.
    access(1'b1, 32'd1024, 32'hDEAD_BEEF, -1, 1'b1, "w1");
    check("w1_sram_hw0", 32'(sram[0]), 32'h0000_BEEF);
    check("w1_sram_hw1", 32'(sram[1]), 32'h0000_DEAD);
    access(1'b0, 32'd1024, 32'd0, -1, 1'b1, "r1");
    // Read with nothing answering on DQ: the controller must leave the bus released.
    access(1'b0, 32'd1025, 32'd0, -1, 1'b0, "r_nodrv");

    // Request withdrawn after the first cycle: write still completes in full.
    access(1'b1, 32'd1032, 32'h1234_5678, 1, 1'b1, "w_drop");
    check("w_drop_sram_hw4", 32'(sram[4]), 32'h0000_5678);
    check("w_drop_sram_hw5", 32'(sram[5]), 32'h0000_1234);
    access(1'b0, 32'd1034, 32'd0, -1, 1'b1, "r_drop");

    // Read held across DONE starts a second access immediately.
    b2b_exp = ref_word(word_of(32'd1028));
    address = 32'd1028;
    rd_en   = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check($sformatf("b2b_ready_%0d", i), 32'(ready), (i % 6 == 5) ? 32'd1 : 32'd0);
      if (i % 6 == 5) check($sformatf("b2b_rdata_%0d", i), read_data, b2b_exp);
      if (i < 11) begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    rd_en  = 1'b0;
    exp_rd = b2b_exp;

    // Randomized traffic against the word-level model.
    for (int n = 0; n < 40; n++) begin
      int unsigned r;
      logic [31:0] a;
      bit wr;
      int drop;
      r  = $urandom_range(0, 9);
      wr = 1'($urandom_range(0, 1));
      if (r < 7) a = 32'd1024 + 32'd4 * $urandom_range(0, 31) + $urandom_range(0, 3);
      else if (r == 7) a = $urandom_range(0, 1023);
      else a = $urandom;
      drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : -1;
      access(wr, a, $urandom, drop, 1'b1, $sformatf("rnd%0d", n));
    end

    // Asynchronous reset in the middle of a write.
    address    = 32'd1024 + 32'd400;
    write_data = 32'hA5A5_5A5A;
    wr_en      = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("mid_we_low", 32'(sram_we_n), 32'd0);
    rst = 1'b0;
    #1;
    check("arst_we_n", 32'(sram_we_n), 32'd1);
    check("arst_oe_n", 32'(sram_oe_n), 32'd1);
    check("arst_dq_released", 32'(sram_dq), 32'h0000_FFFF);
    check("arst_sram_addr", 32'(sram_addr), 32'd0);
    check("arst_read_data", read_data, 32'd0);
    wr_en = 1'b0;
    #1;
    check("arst_ready", 32'(ready), 32'd1);
    exp_rd = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_ready", 32'(ready), 32'd1);
    check("post_rst_we_n", 32'(sram_we_n), 32'd1);
    access(1'b0, 32'd1032, 32'd0, -1, 1'b1, "post_rst_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
